// File: rtl/spi_adc_master_pkg.sv
// Shared definitions for the SPI ADC master.
//   state_t       : controller states IDLE/SETUP/XFER/HOLD/DONE
//   MODE0..MODE3  : SPI mode encodings as {CPOL,CPHA}
//   SS_W(n)       : width of a slave index for n selects, never below 1
package spi_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int SS_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Divider that paces the SPI master: SETUP, HOLD and every SCLK half-period
// are each one tick long.
//   CLOCK_50 : system clock (rising edge)
//   RESET    : synchronous active-high reset
//   en       : count while high; counter is cleared while low
//   tick     : one-cycle pulse on every CLK_DIV-th enabled cycle
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Clearing while disabled makes the first tick after enable land exactly
  // CLK_DIV cycles later, which is what gives SETUP its fixed length.
  assign tick = en && (cnt_reg == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (RESET || !en) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_adc_master.sv
// Parametrised SPI master for the ADC link: one frame per accepted start,
// MSB first, any CPOL/CPHA mode, one of NUM_SS active-low selects.
//   CLOCK_50, RESET        : clock and synchronous active-high reset
//   start, ss_sel, tx_data : request; captured only in IDLE
//   rx_data                : last received frame, updated with done
//   busy, done             : frame in progress / one-cycle completion pulse
//   SPI_MISO, SPI_MOSI, SPI_CLOCK, SPI_SS : board SPI pins
// Optional: define SPI_ADC_MASTER_LOOPBACK_EN to add the 'loopback' input,
// which makes the receiver sample its own MOSI instead of SPI_MISO.
module spi_adc_master
  import spi_adc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_SS  = 4,
  parameter int CLK_DIV = 4,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic                      start,
  input  logic [SS_W(NUM_SS)-1:0]   ss_sel,
  input  logic [DATA_W-1:0]         tx_data,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      done,
`ifdef SPI_ADC_MASTER_LOOPBACK_EN
  input  logic                      loopback,
`endif
  input  logic                      SPI_MISO,
  output logic                      SPI_MOSI,
  output logic                      SPI_CLOCK,
  output logic [NUM_SS-1:0]         SPI_SS
);

  localparam int SS_WIDTH = SS_W(NUM_SS);
  localparam logic [1:0] MODE = {CPOL != 0, CPHA != 0};
  localparam logic IDLE_LVL = (MODE == MODE2) || (MODE == MODE3);
  // CPHA=0 samples on leading edges and shifts on trailing ones; CPHA=1 is
  // the mirror image.
  localparam logic SAMPLE_ON_LEAD = !((MODE == MODE1) || (MODE == MODE3));
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [SS_WIDTH:0] NUM_SS_L = (SS_WIDTH + 1)'(NUM_SS);

  state_t              state_reg;
  logic [HALF_W-1:0]   half_cnt_reg;
  logic [DATA_W-1:0]   tx_shift_reg;
  logic [DATA_W-1:0]   rx_shift_reg;
  logic [DATA_W-1:0]   rx_data_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                mosi_reg;
  logic                sclk_reg;
  logic [NUM_SS-1:0]   ss_reg;

  logic                tick;
  logic                clk_en;
  logic                sel_ok;
  logic [NUM_SS-1:0]   ss_dec;
  logic                rx_bit;
  logic                lead_edge;
  logic                sample_now;
  logic                shift_now;

  assign clk_en = (state_reg == SETUP) || (state_reg == XFER) || (state_reg == HOLD);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .en       (clk_en),
    .tick     (tick)
  );

  // Selects beyond NUM_SS (possible when NUM_SS is not a power of two) are
  // rejected rather than aliased onto a real slave.
  assign sel_ok = ({1'b0, ss_sel} < NUM_SS_L);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
      assign ss_dec[gi] = (ss_sel != SS_WIDTH'(gi));
    end
  endgenerate

`ifdef SPI_ADC_MASTER_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_reg : SPI_MISO;
`else
  assign rx_bit = SPI_MISO;
`endif

  // Even half-period ticks move SCLK away from idle (leading edge).
  assign lead_edge  = ~half_cnt_reg[0];
  assign sample_now = (lead_edge == SAMPLE_ON_LEAD);
  assign shift_now  = (lead_edge != SAMPLE_ON_LEAD);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      sclk_reg     <= IDLE_LVL;
      ss_reg       <= '1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && sel_ok) begin
            state_reg    <= SETUP;
            busy_reg     <= 1'b1;
            ss_reg       <= ss_dec;
            half_cnt_reg <= '0;
            if (SAMPLE_ON_LEAD) begin
              // MSB must already be on the wire before the first leading edge.
              mosi_reg     <= tx_data[DATA_W-1];
              tx_shift_reg <= {tx_data[DATA_W-2:0], 1'b0};
            end else begin
              mosi_reg     <= 1'b0;
              tx_shift_reg <= tx_data;
            end
          end
        end
        SETUP: begin
          if (tick) begin
            state_reg <= XFER;
          end
        end
        XFER: begin
          if (tick) begin
            sclk_reg <= ~sclk_reg;
            if (sample_now) begin
              rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], rx_bit};
            end
            if (shift_now) begin
              mosi_reg     <= tx_shift_reg[DATA_W-1];
              tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
            end
            // Half-period counter stops at its last value; the state change
            // ends the frame instead of a wrap.
            if (half_cnt_reg == HALF_LAST) begin
              state_reg <= HOLD;
            end else begin
              half_cnt_reg <= half_cnt_reg + 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_reg   <= DONE;
            ss_reg      <= '1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            rx_data_reg <= rx_shift_reg;
            mosi_reg    <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign SPI_MOSI  = mosi_reg;
  assign SPI_CLOCK = sclk_reg;
  assign SPI_SS    = ss_reg;

endmodule

// File: tb/tb_spi_adc_master.sv
// Bench for spi_adc_master: four instances (one per SPI mode, 4 selects) plus
// one with three selects for the out-of-range index case. A slave model at
// pin level serves MISO bits and records MOSI on each sampling edge.
module tb_spi_adc_master;

  localparam int DW  = 16;
  localparam int CD  = 2;
  localparam int NM  = 4;
  localparam int LAT = 1 + (2 * DW + 2) * CD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s   [NM];
  logic          start_s [NM];
  logic [1:0]    sel_s   [NM];
  logic [DW-1:0] tx_s    [NM];
  logic [DW-1:0] rx_s    [NM];
  logic          busy_s  [NM];
  logic          done_s  [NM];
  logic          miso_s  [NM];
  logic          mosi_s  [NM];
  logic          sclk_s  [NM];
  logic [3:0]    ss_s    [NM];
`ifdef SPI_ADC_MASTER_LOOPBACK_EN
  logic          lb_s    [NM];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_dut
      spi_adc_master #(
        .DATA_W (DW), .NUM_SS (4), .CLK_DIV (CD), .CPOL (gi / 2), .CPHA (gi % 2)
      ) u_dut (
        .CLOCK_50  (clk),
        .RESET     (rst_s[gi]),
        .start     (start_s[gi]),
        .ss_sel    (sel_s[gi]),
        .tx_data   (tx_s[gi]),
        .rx_data   (rx_s[gi]),
        .busy      (busy_s[gi]),
        .done      (done_s[gi]),
`ifdef SPI_ADC_MASTER_LOOPBACK_EN
        .loopback  (lb_s[gi]),
`endif
        .SPI_MISO  (miso_s[gi]),
        .SPI_MOSI  (mosi_s[gi]),
        .SPI_CLOCK (sclk_s[gi]),
        .SPI_SS    (ss_s[gi])
      );
    end
  endgenerate

  // Three-select instance
  logic          r3, st3, busy3, done3, miso3, mosi3, sclk3;
  logic [1:0]    sel3;
  logic [DW-1:0] tx3, rx3;
  logic [2:0]    ss3;
`ifdef SPI_ADC_MASTER_LOOPBACK_EN
  logic          lb3;
`endif

  spi_adc_master #(
    .DATA_W (DW), .NUM_SS (3), .CLK_DIV (CD), .CPOL (0), .CPHA (0)
  ) u_dut3 (
    .CLOCK_50  (clk),
    .RESET     (r3),
    .start     (st3),
    .ss_sel    (sel3),
    .tx_data   (tx3),
    .rx_data   (rx3),
    .busy      (busy3),
    .done      (done3),
`ifdef SPI_ADC_MASTER_LOOPBACK_EN
    .loopback  (lb3),
`endif
    .SPI_MISO  (miso3),
    .SPI_MOSI  (mosi3),
    .SPI_CLOCK (sclk3),
    .SPI_SS    (ss3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cpol_of(input int m);
    return (m >= 2);
  endfunction

  function automatic logic cpha_of(input int m);
    return ((m % 2) == 1);
  endfunction

  // ---------------- pin-level slave model ----------------
  logic [DW-1:0] slave_word [NM];
  logic [3:0]    exp_ss     [NM];
  logic [DW-1:0] stream     [NM];
  int            k_cnt      [NM];
  int            lead_cnt   [NM];
  int            ss_bad     [NM];
  int            edge_bad   [NM];
  logic          prev_sclk  [NM];
  logic          prev_mosi  [NM];
  logic [3:0]    prev_ss    [NM] = '{default: 4'hF};
  bit            chg, lead;

  always @(negedge clk) begin
    for (int m = 0; m < NM; m++) begin
      if (prev_ss[m] == 4'hF && ss_s[m] != 4'hF) begin
        k_cnt[m] = 0; lead_cnt[m] = 0; stream[m] = '0; ss_bad[m] = 0; edge_bad[m] = 0;
      end
      chg  = (sclk_s[m] != prev_sclk[m]);
      lead = chg && (prev_sclk[m] == cpol_of(m));
      if (ss_s[m] != 4'hF) begin
        if (ss_s[m] != exp_ss[m]) ss_bad[m]++;
        if (lead) lead_cnt[m]++;
        // Both ends sample on the same edge type: leading for CPHA=0.
        if (chg && (lead != cpha_of(m))) begin
          stream[m] = {stream[m][DW-2:0], mosi_s[m]};
          k_cnt[m]++;
        end
        // MOSI may only move on the shift edge once the frame is under way.
        if (prev_ss[m] != 4'hF && mosi_s[m] != prev_mosi[m] && !(chg && (lead == cpha_of(m))))
          edge_bad[m]++;
      end
      miso_s[m]    = (k_cnt[m] < DW) ? slave_word[m][DW-1-k_cnt[m]] : 1'b0;
      prev_sclk[m] = sclk_s[m];
      prev_mosi[m] = mosi_s[m];
      prev_ss[m]   = ss_s[m];
    end
  end

  // One complete frame on instance m; returns at the negedge of the done cycle.
  task automatic do_frame(input int m, input logic [1:0] sel, input logic [DW-1:0] tx,
                          input logic [DW-1:0] sw, input logic [DW-1:0] exp_rx, input bit poke);
    int cyc;
    int lat;
    logic busy_at_done;
    lat = -1;
    busy_at_done = 1'bx;
    slave_word[m] = sw;
    exp_ss[m] = ~(4'b0001 << sel);
    @(negedge clk);
    start_s[m] = 1'b1; sel_s[m] = sel; tx_s[m] = tx;
    @(negedge clk);
    start_s[m] = 1'b0; tx_s[m] = DW'($urandom);
    cyc = 1;
    chk("busy_after_start", 64'(busy_s[m]), 64'(1));
    while (cyc < LAT + 50 && lat < 0) begin
      if (done_s[m]) begin
        lat = cyc;
        busy_at_done = busy_s[m];
      end else begin
        if (poke && cyc == 20) begin start_s[m] = 1'b1; tx_s[m] = '1; end
        if (poke && cyc == 21) start_s[m] = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    chk("latency", 64'(lat), 64'(LAT));
    chk("busy_at_done", 64'(busy_at_done), 64'(0));
    chk("rx_data", 64'(rx_s[m]), 64'(exp_rx));
    chk("mosi_stream", 64'(stream[m]), 64'(tx));
    chk("sclk_pulses", 64'(lead_cnt[m]), 64'(DW));
    chk("ss_pattern", 64'(ss_bad[m]), 64'(0));
    chk("mosi_edge", 64'(edge_bad[m]), 64'(0));
    chk("ss_released", 64'(ss_s[m]), 64'(4'hF));
    chk("sclk_idle", 64'(sclk_s[m]), 64'(cpol_of(m)));
    $display("frame mode=%0d sel=%0d tx=%h rx=%h lat=%0d", m, sel, tx, rx_s[m], lat);
  endtask

  initial begin
    int cyc;
    int cnt;
    logic [DW-1:0] rt, rs;
    for (int m = 0; m < NM; m++) begin
      rst_s[m] = 1'b1; start_s[m] = 1'b0; sel_s[m] = '0; tx_s[m] = '0;
      slave_word[m] = '0; exp_ss[m] = 4'hF;
`ifdef SPI_ADC_MASTER_LOOPBACK_EN
      lb_s[m] = 1'b0;
`endif
    end
    r3 = 1'b1; st3 = 1'b0; sel3 = '0; tx3 = '0; miso3 = 1'b0;
`ifdef SPI_ADC_MASTER_LOOPBACK_EN
    lb3 = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state of every instance
    for (int m = 0; m < NM; m++) begin
      chk("rst_ss", 64'(ss_s[m]), 64'(4'hF));
      chk("rst_sclk", 64'(sclk_s[m]), 64'(cpol_of(m)));
      chk("rst_mosi_busy_done", 64'({mosi_s[m], busy_s[m], done_s[m]}), 64'(0));
      chk("rst_rx", 64'(rx_s[m]), 64'(0));
    end
    for (int m = 0; m < NM; m++) rst_s[m] = 1'b0;
    r3 = 1'b0;
    @(negedge clk);

    // Mode 0 and mode 3 directed frames
    do_frame(0, 2'd2, 16'hA5C3, 16'h3C5A, 16'h3C5A, 1'b0);
    do_frame(3, 2'd0, 16'h0001, 16'h8000, 16'h8000, 1'b0);
    repeat (3) @(negedge clk);
    chk("mode3_sclk_idle_high", 64'(sclk_s[3]), 64'(1));

    // Reset in the middle of XFER, after bit 7
    slave_word[0] = 16'hFFFF; exp_ss[0] = 4'b1110;
    @(negedge clk);
    start_s[0] = 1'b1; sel_s[0] = 2'd0; tx_s[0] = 16'hC0DE;
    @(negedge clk);
    start_s[0] = 1'b0;
    cyc = 0;
    while (k_cnt[0] < 8 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reach_bit7", 64'(k_cnt[0] >= 8), 64'(1));
    rst_s[0] = 1'b1;
    @(negedge clk);
    chk("abort_ss", 64'(ss_s[0]), 64'(4'hF));
    chk("abort_sclk", 64'(sclk_s[0]), 64'(0));
    chk("abort_busy_done", 64'({busy_s[0], done_s[0]}), 64'(0));
    chk("abort_rx", 64'(rx_s[0]), 64'(0));
    rst_s[0] = 1'b0;
    cnt = 0;
    repeat (LAT + 10) begin @(negedge clk); if (done_s[0]) cnt++; end
    chk("abort_no_done", 64'(cnt), 64'(0));

    // Start while busy is ignored; no queued frame afterwards
    do_frame(0, 2'd1, 16'h6B2D, 16'h1357, 16'h1357, 1'b1);
    cnt = 0;
    repeat (LAT + 10) begin @(negedge clk); if (done_s[0] || busy_s[0]) cnt++; end
    chk("busy_start_ignored", 64'(cnt), 64'(0));

    // Start held only in the DONE cycle is ignored
    do_frame(1, 2'd3, 16'h0F0F, 16'hF00F, 16'hF00F, 1'b0);
    start_s[1] = 1'b1; tx_s[1] = 16'hBEEF;
    @(negedge clk);
    start_s[1] = 1'b0;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (busy_s[1] || ss_s[1] != 4'hF) cnt++; end
    chk("done_cycle_start_ignored", 64'(cnt), 64'(0));

    // Randomized back-to-back frames in every mode
    for (int m = 0; m < NM; m++) begin
      for (int f = 0; f < 3; f++) begin
        rt = DW'($urandom);
        rs = DW'($urandom);
        do_frame(m, 2'($urandom_range(0, 3)), rt, rs, rs, 1'b0);
      end
    end

`ifdef SPI_ADC_MASTER_LOOPBACK_EN
    for (int m = 0; m < NM; m++) begin
      lb_s[m] = 1'b1;
      do_frame(m, 2'd1, 16'h5A3C, 16'h0000, 16'h5A3C, 1'b0);
      lb_s[m] = 1'b0;
    end
`endif

    // Out-of-range select on the three-select instance
    @(negedge clk);
    st3 = 1'b1; sel3 = 2'd3; tx3 = 16'h1234;
    @(negedge clk);
    st3 = 1'b0;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (ss3 != 3'b111 || busy3 || done3 || sclk3 || mosi3) cnt++;
    end
    chk("oor_no_activity", 64'(cnt), 64'(0));
    chk("oor_rx", 64'(rx3), 64'(0));
    st3 = 1'b1; sel3 = 2'd2;
    @(negedge clk);
    st3 = 1'b0;
    chk("ns3_valid_busy", 64'(busy3), 64'(1));
    chk("ns3_valid_ss", 64'(ss3), 64'(3'b011));
    cyc = 1;
    while (!done3 && cyc < LAT + 50) begin @(negedge clk); cyc++; end
    chk("ns3_latency", 64'(cyc), 64'(LAT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
